// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register file geometry shared by write-back, file and issue logic
package regfile_wb_arbiter_pkg;
  localparam int NUM_REG = 4;
  localparam int ADR_W = 2;
  localparam int DATA_W = 48;
  typedef logic [ADR_W-1:0] reg_adr_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over a valid vector with a registered search pointer
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      gidx,
  output logic               hit
);
  logic [PW-1:0] ptr;
  int k;
  always_comb begin
    grant = '0;
    gidx = '0;
    hit = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!hit && !hold && valid[k]) begin
        grant[k] = 1'b1;
        gidx = PW'(k);
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (hit) ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + PW'(1);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back port arbiter plus pending-write hazard scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 48,
  parameter int ADR_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADR_W-1:0]  req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_hold,
  output logic                      rf_write_en,
  output logic [ADR_W-1:0]          rf_write_adr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      reserve_en,
  input  logic [ADR_W-1:0]          reserve_adr,
  input  logic                      rd_use_a,
  input  logic                      rd_use_b,
  input  logic [ADR_W-1:0]          rd_adr_a,
  input  logic [ADR_W-1:0]          rd_adr_b,
  output logic                      stall,
  output logic [NUM_REG-1:0]        busy,
  output logic                      reserve_err
);
  localparam int PW = (NUM_REQ > 2) ? 2 : 1;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0] gidx;
  logic hit;
  logic [ADR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REG-1:0] clr, set;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .clk(clk), .rst_n(rst_n), .valid(req_valid), .hold(wb_hold),
    .grant(grant), .gidx(gidx), .hit(hit)
  );
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign sel_adr = req_adr[int'(gidx)*ADR_W +: ADR_W];
  assign sel_data = req_data[int'(gidx)*DATA_W +: DATA_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_write_en <= 1'b0;
      rf_write_adr <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= hit;
      if (hit) begin
        rf_write_adr <= sel_adr;
        rf_write_data <= sel_data;
      end
    end
  // a reservation landing on the register being written survives the clear
  assign clr = rf_write_en ? (NUM_REG'(1) << rf_write_adr) : '0;
  assign set = reserve_en ? (NUM_REG'(1) << reserve_adr) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      reserve_err <= 1'b0;
    end else begin
      busy <= (busy & ~clr) | set;
      reserve_err <= |(set & busy & ~clr);
    end
  assign stall = (rd_use_a & busy[rd_adr_a]) | (rd_use_b & busy[rd_adr_b]);
endmodule
